// File: rtl/fruit_pkg.sv
// Shared types and constants for the fruit layer: FSM state encoding,
// type-field width helper and default fruit parameters.
package fruit_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REDUCE,
        STORE,
        DONE
    } fruit_alloc_state_t;

    localparam int FRUIT_NUM_TYPES = 3;
    localparam int FRUIT_SEED_W    = 8;

    // Width of one packed type field; never narrower than one bit.
    function automatic int type_width(input int num_types);
        int w;
        w = $clog2(num_types);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/fruit_mod_reducer.sv
// One step of a restoring serial modulo: shifts a seed bit into the
// running remainder and subtracts NUM_TYPES when it overflows.
module fruit_mod_reducer
    import fruit_pkg::*;
#(
    parameter  int NUM_TYPES = FRUIT_NUM_TYPES,
    localparam int RW        = type_width(NUM_TYPES) + 1
) (
    input  logic [RW-1:0] r,
    input  logic          seed_bit,
    input  logic          clear,
    input  logic          enable,
    output logic [RW-1:0] r_next
);

    // r < NUM_TYPES <= 2^(RW-1), so the shifted value always fits in RW bits
    localparam logic [RW-1:0] NT = RW'(NUM_TYPES);

    logic [RW-1:0] t;

    // Clear wins over a step; otherwise hold the remainder
    always_comb begin
        t      = {r[RW-2:0], seed_bit};
        r_next = r;
        if (clear)
            r_next = '0;
        else if (enable)
            r_next = (t >= NT) ? (t - NT) : t;
    end

endmodule

// File: rtl/fruit_type_allocator.sv
// Fruit-type generator: snapshots per-slot seeds on start, reduces each
// seed modulo NUM_TYPES bit-serially and commits all slots at once.
module fruit_type_allocator
    import fruit_pkg::*;
#(
    parameter  int NUM_FRUITS   = 6,
    parameter  int SEED_W       = FRUIT_SEED_W,
    parameter  int NUM_TYPES    = FRUIT_NUM_TYPES,
    parameter  bit AVOID_REPEAT = 1'b0,
    localparam int TYPE_W       = type_width(NUM_TYPES)
) (
    input  logic                         clk,
    input  logic                         resetN,
    input  logic                         start,
    input  logic [NUM_FRUITS*SEED_W-1:0] seed_vec,
    input  logic [NUM_FRUITS-1:0]        reroll_mask,
    output logic [NUM_FRUITS*TYPE_W-1:0] fruits_t,
    output logic                         fruits_valid,
    output logic                         busy,
    output logic                         done
);

    localparam int RW     = TYPE_W + 1;
    localparam int SLOT_W = (NUM_FRUITS > 1) ? $clog2(NUM_FRUITS) : 1;
    localparam int BIT_W  = (SEED_W > 1) ? $clog2(SEED_W) : 1;

    fruit_alloc_state_t state, state_nx;

    logic [NUM_FRUITS*SEED_W-1:0] seed_snap;
    logic [NUM_FRUITS-1:0]        mask_snap;
    logic [NUM_FRUITS*TYPE_W-1:0] shadow, shadow_nx;
    logic [SLOT_W-1:0]            slot;
    logic [BIT_W-1:0]             bidx;
    logic [RW-1:0]                r, r_next, r_inc;
    logic [TYPE_W-1:0]            committed, wr_val;
    logic                         cur_bit, last_slot, last_bit;
    logic                         red_clear, red_en;
    int                           sofs, tofs;

    fruit_mod_reducer #(.NUM_TYPES(NUM_TYPES)) u_red (
        .r        (r),
        .seed_bit (cur_bit),
        .clear    (red_clear),
        .enable   (red_en),
        .r_next   (r_next)
    );

    // Slot/bit selection, no-repeat adjustment and the merged shadow value
    always_comb begin
        sofs      = int'(slot) * SEED_W + int'(bidx);
        tofs      = int'(slot) * TYPE_W;
        cur_bit   = seed_snap[sofs];
        committed = fruits_t[tofs +: TYPE_W];
        last_slot = (slot == SLOT_W'(NUM_FRUITS - 1));
        last_bit  = (bidx == '0);
        r_inc     = r + 1'b1;
        wr_val    = r[TYPE_W-1:0];
        if (AVOID_REPEAT && (NUM_TYPES > 1) && (r[TYPE_W-1:0] == committed))
            wr_val = (r_inc == RW'(NUM_TYPES)) ? '0 : r_inc[TYPE_W-1:0];
        shadow_nx = shadow;
        if (mask_snap[slot])
            shadow_nx[tofs +: TYPE_W] = wr_val;
        red_clear = ((state == IDLE) && start) || (state == STORE);
        red_en    = (state == REDUCE);
    end

    // Next-state and status outputs
    always_comb begin
        state_nx = state;
        busy     = (state != IDLE);
        done     = (state == DONE);
        case (state)
            IDLE:    if (start) state_nx = REDUCE;
            REDUCE:  if (last_bit) state_nx = STORE;
            STORE:   state_nx = last_slot ? DONE : REDUCE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!resetN) state <= IDLE;
        else         state <= state_nx;
    end

    // Snapshots, counters, remainder and the shadow/commit registers
    always_ff @(posedge clk) begin
        if (!resetN) begin
            seed_snap    <= '0;
            mask_snap    <= '0;
            shadow       <= '0;
            slot         <= '0;
            bidx         <= '0;
            r            <= '0;
            fruits_t     <= '0;
            fruits_valid <= 1'b0;
        end else begin
            r <= r_next;
            case (state)
                IDLE: if (start) begin
                    seed_snap <= seed_vec;
                    mask_snap <= reroll_mask;
                    slot      <= '0;
                    bidx      <= BIT_W'(SEED_W - 1);
                    shadow    <= fruits_t;
                end
                REDUCE: bidx <= bidx - 1'b1;
                STORE: begin
                    shadow <= shadow_nx;
                    if (last_slot) begin
                        fruits_t     <= shadow_nx;
                        fruits_valid <= 1'b1;
                    end else begin
                        slot <= slot + 1'b1;
                        bidx <= BIT_W'(SEED_W - 1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/fruit_type_allocator.md
# fruit_type_allocator

Parametrised fruit-type generator for the Donkey Kong Jr. fruit layer. On a start pulse it snapshots one random seed per fruit slot and reduces each seed modulo `NUM_TYPES`, one bit per cycle, on a shared serial datapath. The results are committed atomically to a packed type bus that the fruit drawers and the collision/score logic consume. Per-slot re-roll masking and an optional no-repeat rule allow single eaten fruits to be replaced without disturbing the others.

## Interface
- `NUM_FRUITS`, 6, number of fruit slots (1..16)
- `SEED_W`, 8, width of each per-slot random seed
- `NUM_TYPES`, 3, number of distinct fruit types (1..2^TYPE_W)
- `AVOID_REPEAT`, 0, 1 = a re-rolled slot never keeps its previous type when `NUM_TYPES` > 1
- `clk`  in  1  system clock
- `resetN`  in  1  reset; one clock; reset is synchronous and active-low
- `start`  in  1  request a re-roll pass; sampled only in IDLE
- `seed_vec`  in  NUM_FRUITS*SEED_W  per-slot seeds; slot k occupies bits [k*SEED_W +: SEED_W]
- `reroll_mask`  in  NUM_FRUITS  1 = slot is rewritten by this pass; sampled with `start`
- `fruits_t`  out  NUM_FRUITS*TYPE_W  committed types; slot k occupies bits [k*TYPE_W +: TYPE_W]
- `fruits_valid`  out  1  high once the first pass has committed; stays high until reset
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse in the cycle the new `fruits_t` first becomes visible

## Operation
- `TYPE_W` = max(1, $clog2(NUM_TYPES)). The remainder register is TYPE_W+1 bits wide.
- FSM states are IDLE, REDUCE, STORE and DONE.
- **IDLE:** when `start`=1, the block:
  - latches `seed_vec` and `reroll_mask` into snapshots;
  - sets slot index to 0, remainder r to 0 and bit index to SEED_W-1;
  - loads the shadow register from `fruits_t`;
  - moves to REDUCE.
- **REDUCE:** restoring serial modulo, MSB first.
  - t = (r<<1) | seed[slot][bit]; r = (t >= NUM_TYPES) ? t - NUM_TYPES : t.
  - After SEED_W cycles, moves to STORE.
- **STORE:** if the mask bit is set, the block writes the shadow slot with r.
  - When AVOID_REPEAT=1, NUM_TYPES>1 and r equals the committed `fruits_t` slot value, it writes (r+1 == NUM_TYPES) ? 0 : r+1 instead.
  - A masked-off slot still takes the full SEED_W+1 cycles, so latency is mask-independent.
  - If this is not the last slot, the block increments the slot index, resets r and the bit index, and returns to REDUCE.
  - If it is the last slot, `fruits_t` is loaded from the shadow (including this slot) on the same edge, and the block moves to DONE.
- **DONE:** `done`=1 and `fruits_valid` becomes 1 on this edge; the block returns to IDLE.
- NUM_TYPES=1: every written slot is 0.
- `start` outside IDLE is ignored; it is not queued.
- Seed and mask changes after the start cycle have no effect on the running pass.

## Timing
- Cycle 0 is the cycle in which `start` is sampled high in IDLE.
- `busy` is high in cycles 1 .. L, where L = NUM_FRUITS*(SEED_W+1)+1. With defaults, L = 55.
- `done` and the new `fruits_t` appear in cycle L. IDLE is reached in cycle L+1, where a new `start` is accepted.
- `fruits_t` never shows a partial pass; it changes only on the edge into DONE.
- Reset values: `fruits_t`=0, `fruits_valid`=0, `busy`=0, `done`=0, FSM=IDLE, shadow/snapshots/r=0.
- Reset asserted mid-pass aborts the pass: all outputs read their reset values in the next cycle, and no `done` is produced.

## Structure
- `fruit_pkg` holds:
  - the FSM state enum `fruit_alloc_state_t`;
  - the function `type_width(num_types)`;
  - the default constants `FRUIT_NUM_TYPES`=3 and `FRUIT_SEED_W`=8, shared with the drawers and score logic.
- Sub-module `fruit_mod_reducer` implements the one-bit restoring modulo step: inputs r, bit, clear, enable; output next r. The parent owns the FSM, counters and registers.

## Test plan
- **Full pass, defaults:** seeds slot0..5 = 200, 7, 9, 255, 0, 128 with mask=6'h3F and start. Required: `done` in cycle 55, `fruits_t`=12'h806, `fruits_valid`=1.
- **Partial re-roll:** after the previous pass, mask=6'b000001 with slot0 seed=4. Required: `fruits_t`=12'h805, and slots 1..5 stay unchanged throughout.
- **No-repeat:** with AVOID_REPEAT=1, slot0 committed=2, seed=5 and mask=1. Required: slot0=0. With seed=4, slot0=1 (no adjustment).
- **Busy-ignore and input freeze:**
  - Pulse `start` at cycle 10 and change `seed_vec` at cycle 3.
  - Required: only one `done`, in cycle 55, with results taken from the cycle-0 seeds.
  - A `start` in cycle 56 is accepted.
- **Reset mid-pass:** assert `resetN`=0 at cycle 20. Required: at cycle 21, `busy`=0, `fruits_t`=0 and `fruits_valid`=0, and no `done` appears.
- **Alternate parameters:** NUM_TYPES=5, NUM_FRUITS=2, seeds 254 and 13. Required: `done` in cycle 19, with slot0=4 and slot1=3 on the 3-bit fields.
